// File: rtl/unlock_check.sv
// unlock_check: holds only the encoded secret and sweeps candidates 0,1,2,...
// through the same encoder until an encoding matches, then flags the lock open.
`default_nettype none

module unlock_check #(
  parameter int                CODE_W = 8,
  parameter logic [CODE_W-1:0] SECRET = 8'hA5,
  parameter logic [CODE_W-1:0] KEY    = 8'h3C,
  parameter int                ROT    = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic INIT,
  output logic check
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SCAN     = 2'd1,
    UNLOCKED = 2'd2,
    FAIL     = 2'd3
  } state_t;

  localparam logic [CODE_W-1:0] C_ONE = CODE_W'(1);

  // Rotate via a doubled word so ROT == 0 needs no special case.
  function automatic logic [CODE_W-1:0] enc(input logic [CODE_W-1:0] x);
    logic [2*CODE_W-1:0] dbl;
    dbl = {x ^ KEY, x ^ KEY} << ROT;
    return dbl[2*CODE_W-1:CODE_W];
  endfunction

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   cand_q, cand_d;
  logic [CODE_W-1:0]   stored_enc_q;
  logic                check_q, check_d;

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    if (INIT) begin
      state_d = SCAN;
      cand_d  = '0;
    end else begin
      case (state_q)
        SCAN: begin
          if (enc(cand_q) == stored_enc_q) begin
            state_d = UNLOCKED;
          end else if (&cand_q) begin
            state_d = FAIL;
          end else begin
            cand_d = cand_q + C_ONE;
          end
        end
        default: ;
      endcase
    end
    check_d = (state_d == UNLOCKED);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      cand_q       <= '0;
      check_q      <= 1'b0;
      stored_enc_q <= enc(SECRET);
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      check_q      <= check_d;
      stored_enc_q <= stored_enc_q;
    end
  end

  assign check = check_q;

endmodule

`default_nettype wire

// File: tb/tb_unlock_check.sv
// tb_unlock_check: three lock instances (secrets A5, 00, FF) driven by shared
// random INIT/RST traffic and compared every cycle against an edge-count model.
`default_nettype none

module tb_unlock_check;

  logic clk;
  logic rst;
  logic init;
  logic check_a, check_z, check_f;

  int n_checks = 0;
  int n_errors = 0;

  // Edges since the last high-INIT edge; -1 means idle since reset.
  int          since [3];
  logic [7:0]  secret [3];

  unlock_check #(.CODE_W(8), .SECRET(8'hA5), .KEY(8'h3C), .ROT(3)) dut_a (
    .CLK(clk), .RST(rst), .INIT(init), .check(check_a)
  );
  unlock_check #(.CODE_W(8), .SECRET(8'h00), .KEY(8'h3C), .ROT(3)) dut_z (
    .CLK(clk), .RST(rst), .INIT(init), .check(check_z)
  );
  unlock_check #(.CODE_W(8), .SECRET(8'hFF), .KEY(8'h3C), .ROT(3)) dut_f (
    .CLK(clk), .RST(rst), .INIT(init), .check(check_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_check(input int i);
    return (since[i] > int'(secret[i]));
  endfunction

  function automatic logic [7:0] exp_cand(input int i);
    if (since[i] < 0) return 8'h00;
    if (since[i] < int'(secret[i])) return 8'(since[i]);
    return secret[i];
  endfunction

  task automatic compare_all();
    check_eq("check_a5", {31'd0, check_a}, {31'd0, exp_check(0)});
    check_eq("check_00", {31'd0, check_z}, {31'd0, exp_check(1)});
    check_eq("check_ff", {31'd0, check_f}, {31'd0, exp_check(2)});
    check_eq("cand_a5", {24'd0, dut_a.cand_q}, {24'd0, exp_cand(0)});
    check_eq("cand_00", {24'd0, dut_z.cand_q}, {24'd0, exp_cand(1)});
    check_eq("cand_ff", {24'd0, dut_f.cand_q}, {24'd0, exp_cand(2)});
  endtask

  task automatic step(input logic rst_v, input logic init_v);
    @(negedge clk);
    rst  = rst_v;
    init = init_v;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst_v)             since[i] = -1;
      else if (init_v)       since[i] = 0;
      else if (since[i] >= 0 && since[i] < 100000) since[i] = since[i] + 1;
    end
    #1;
    compare_all();
  endtask

  task automatic run_idle(input int n);
    for (int c = 0; c < n; c++) step(1'b0, 1'b0);
  endtask

  initial begin
    int hold, len, rst_at;
    secret[0] = 8'hA5;
    secret[1] = 8'h00;
    secret[2] = 8'hFF;
    for (int i = 0; i < 3; i++) since[i] = -1;
    rst  = 1'b1;
    init = 1'bx;

    // Reset with INIT unknown
    step(1'b1, 1'bx);
    step(1'b1, 1'b0);
    check_eq("enc_a5", {24'd0, dut_a.stored_enc_q}, 32'hCC);
    check_eq("enc_00", {24'd0, dut_z.stored_enc_q}, 32'hE1);
    check_eq("enc_ff", {24'd0, dut_f.stored_enc_q}, 32'h1E);
    run_idle(20);

    // Basic unlock, long enough for the all-ones secret
    step(1'b0, 1'b1);
    run_idle(310);

    // Restart while unlocked
    step(1'b0, 1'b1);
    run_idle(200);

    // Mid-scan reset, then stay idle without INIT
    step(1'b0, 1'b1);
    run_idle(50);
    step(1'b1, 1'b0);
    run_idle(300);

    // Held INIT
    for (int c = 0; c < 10; c++) step(1'b0, 1'b1);
    run_idle(270);

    // Random traffic: random INIT hold lengths, run lengths and mid-run resets
    for (int it = 0; it < 16; it++) begin
      hold   = $urandom_range(1, 10);
      len    = $urandom_range(0, 300);
      rst_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 300) : -1;
      for (int c = 0; c < hold; c++) step(1'b0, 1'b1);
      for (int c = 0; c < len; c++) begin
        if (c == rst_at) step(1'b1, 1'b0);
        else             step(1'b0, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
